// File: rtl/connect4_pkg.sv
// Shared Connect4 controller definitions: FSM state codes, game status and player codes,
// and the default board geometry.
package connect4_pkg;

  localparam int NUM_COLS_DEF = 4;
  localparam int NUM_ROWS_DEF = 4;
  localparam int CNT_W_DEF    = 3;

  localparam logic [2:0] ST_WAIT_MOVE = 3'd0;
  localparam logic [2:0] ST_CHECK     = 3'd1;
  localparam logic [2:0] ST_COMMIT    = 3'd2;
  localparam logic [2:0] ST_EVAL      = 3'd3;
  localparam logic [2:0] ST_GAME_OVER = 3'd4;

  typedef enum logic [1:0] {
    GS_PLAYING = 2'b00,
    GS_P1_WIN  = 2'b01,
    GS_P2_WIN  = 2'b10,
    GS_DRAW    = 2'b11
  } game_status_e;

  typedef enum logic {
    PLAYER1 = 1'b0,
    PLAYER2 = 1'b1
  } player_e;

  // Detector code 11 means "illegal/ignored" and must not end the game.
  function automatic logic is_win(input logic [1:0] det);
    return (det == GS_P1_WIN) || (det == GS_P2_WIN);
  endfunction

endpackage

// File: rtl/turn_sequencer_if.sv
// Move request handshake plus the datapath link (column counters, detector, add strobe)
// between the player/board logic and the turn sequencer.
interface turn_sequencer_if
  import connect4_pkg::*;
#(
  parameter int NUM_COLS = NUM_COLS_DEF,
  parameter int CNT_W    = CNT_W_DEF
);

  logic                      move_valid;
  logic [3:0]                move_col;
  logic                      move_ready;
  logic [NUM_COLS*CNT_W-1:0] col_counts;
  logic [1:0]                det_status;
  logic                      add;
  logic [3:0]                add_col;

  modport master (
    output move_valid, move_col, col_counts, det_status,
    input  move_ready, add, add_col
  );

  modport slave (
    input  move_valid, move_col, col_counts, det_status,
    output move_ready, add, add_col
  );

endinterface

// File: rtl/turn_timer.sv
// Per-turn timer: enabled up-counter with clear and a terminal-count flag at TIMEOUT_CYC-1.
// TIMEOUT_CYC of 0 disables expiry entirely.
module turn_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic run_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TC_VAL = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (run_i && (TIMEOUT_CYC != 0))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset)
      cnt_q <= '0;
    else if (en_i)
      cnt_q <= cnt_d;
  end

  assign tc_o = (TIMEOUT_CYC != 0) && (cnt_q == TC_VAL);

endmodule

// File: rtl/turn_sequencer.sv
// Move-level Connect4 controller: accepts column requests, rejects illegal moves, issues the
// add strobe, waits on the winner detector and tracks turn, timeout, draw and game-over.
//
// state        | meaning
// WAIT_MOVE    | ready for a request; turn timer running
// CHECK        | validate latched column against range and fill count
// COMMIT       | add strobe to counters/board, bump move count
// EVAL         | wait out detector latency, then sample det_status
// GAME_OVER    | sticky until reset
module turn_sequencer
  import connect4_pkg::*;
#(
  parameter int NUM_COLS    = NUM_COLS_DEF,
  parameter int NUM_ROWS    = NUM_ROWS_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int EVAL_WAIT   = 2,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  turn_sequencer_if.slave       bus,
  output logic                  player_turn,
  output logic [1:0]            game_status,
  output logic                  reject,
  output logic                  timeout,
  output logic [2:0]            state
);

  localparam int TOTAL = NUM_COLS * NUM_ROWS;
  localparam int MW    = $clog2(TOTAL + 1);
  localparam int EWW   = (EVAL_WAIT > 2) ? $clog2(EVAL_WAIT) : 1;
  localparam int CW1   = CNT_W + 1;

  localparam logic [MW-1:0]  TOTAL_L = MW'(TOTAL);
  localparam logic [EWW-1:0] EW_LOAD = (EVAL_WAIT > 0) ? EWW'(EVAL_WAIT - 1) : '0;
  localparam logic [4:0]     COLS_L  = 5'(NUM_COLS);
  localparam logic [CW1-1:0] ROWS_L  = CW1'(NUM_ROWS);

  logic [2:0]     state_q, state_d;
  logic [3:0]     col_q, col_d;
  logic [3:0]     add_col_q, add_col_d;
  logic           turn_q, turn_d;
  logic [1:0]     gs_q, gs_d;
  logic [MW-1:0]  moves_q, moves_d;
  logic [EWW-1:0] ew_q, ew_d;
  logic           add_q, add_d;
  logic           reject_q, reject_d;
  logic           timeout_q, timeout_d;
  logic           ready_q, ready_d;

  logic             hs;
  logic             tmr_run, tmr_clr, tmr_tc;
  logic [CNT_W-1:0] col_cnt;
  logic             col_illegal;

  assign hs = bus.move_valid & ready_q & enable;

  turn_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .en_i  (enable),
    .run_i (tmr_run),
    .clr_i (tmr_clr),
    .tc_o  (tmr_tc)
  );

  always_comb begin
    col_cnt = '0;
    for (int i = 0; i < NUM_COLS; i++)
      if (col_q == 4'(i))
        col_cnt = bus.col_counts[i*CNT_W +: CNT_W];
    col_illegal = ({1'b0, col_q} >= COLS_L) || ({1'b0, col_cnt} >= ROWS_L);
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    add_col_d = add_col_q;
    turn_d    = turn_q;
    gs_d      = gs_q;
    moves_d   = moves_q;
    ew_d      = ew_q;
    add_d     = 1'b0;
    reject_d  = 1'b0;
    timeout_d = 1'b0;
    tmr_run   = 1'b0;
    tmr_clr   = 1'b0;
    case (state_q)
      ST_WAIT_MOVE: begin
        // A handshake on the expiry cycle takes priority over the forfeit.
        if (hs) begin
          col_d   = bus.move_col;
          state_d = ST_CHECK;
        end else if (tmr_tc) begin
          timeout_d = 1'b1;
          turn_d    = ~turn_q;
          tmr_clr   = 1'b1;
        end else begin
          tmr_run = 1'b1;
        end
      end
      ST_CHECK: begin
        if (col_illegal) begin
          reject_d = 1'b1;
          state_d  = ST_WAIT_MOVE;
        end else begin
          add_d     = 1'b1;
          add_col_d = col_q;
          state_d   = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (moves_q != TOTAL_L)
          moves_d = moves_q + 1'b1;
        ew_d    = EW_LOAD;
        state_d = ST_EVAL;
      end
      ST_EVAL: begin
        if (ew_q != '0) begin
          ew_d = ew_q - 1'b1;
        end else if (is_win(bus.det_status)) begin
          gs_d    = bus.det_status;
          state_d = ST_GAME_OVER;
        end else if (moves_q == TOTAL_L) begin
          gs_d    = GS_DRAW;
          state_d = ST_GAME_OVER;
        end else begin
          turn_d  = ~turn_q;
          tmr_clr = 1'b1;
          state_d = ST_WAIT_MOVE;
        end
      end
      ST_GAME_OVER: ;
      default: state_d = ST_WAIT_MOVE;
    endcase
    ready_d = (state_d == ST_WAIT_MOVE);
  end

  // Pulses stay latched while disabled so they surface on the next enabled cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_WAIT_MOVE;
      col_q     <= '0;
      add_col_q <= '0;
      turn_q    <= PLAYER1;
      gs_q      <= GS_PLAYING;
      moves_q   <= '0;
      ew_q      <= '0;
      add_q     <= 1'b0;
      reject_q  <= 1'b0;
      timeout_q <= 1'b0;
      ready_q   <= 1'b1;
    end else if (enable) begin
      state_q   <= state_d;
      col_q     <= col_d;
      add_col_q <= add_col_d;
      turn_q    <= turn_d;
      gs_q      <= gs_d;
      moves_q   <= moves_d;
      ew_q      <= ew_d;
      add_q     <= add_d;
      reject_q  <= reject_d;
      timeout_q <= timeout_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.move_ready = ready_q & enable;
  assign bus.add        = add_q & enable;
  assign bus.add_col    = add_col_q;
  assign player_turn    = turn_q;
  assign game_status    = gs_q;
  assign reject         = reject_q & enable;
  assign timeout        = timeout_q & enable;
  assign state          = state_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: directed scenarios plus random play against a move-timeline model
// that owns the column counters and checks every cycle.
module tb_turn_sequencer;
  import connect4_pkg::*;

  localparam int NC = 4;
  localparam int NR = 4;
  localparam int CW = 3;
  localparam int EW = 2;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       player_turn;
  logic [1:0] game_status;
  logic       reject;
  logic       timeout;
  logic [2:0] state;

  turn_sequencer_if #(.NUM_COLS(NC), .CNT_W(CW)) bus();

  turn_sequencer #(
    .NUM_COLS    (NC),
    .NUM_ROWS    (NR),
    .CNT_W       (CW),
    .EVAL_WAIT   (EW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .bus         (bus),
    .player_turn (player_turn),
    .game_status (game_status),
    .reject      (reject),
    .timeout     (timeout),
    .state       (state)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int n_to_dut = 0;

  // Model: m_phase = enabled cycles since the accepting handshake (0 idle, -1 game over).
  int h [NC];
  int m_phase, m_col, m_status, m_moves, m_timer, m_add_col;
  bit m_turn, m_add_vis, m_rej_vis, m_to_vis;
  bit m_known = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) h[i] = 0;
    m_phase = 0; m_col = 0; m_status = 0; m_moves = 0; m_timer = 0; m_add_col = 0;
    m_turn = 1'b0; m_add_vis = 1'b0; m_rej_vis = 1'b0; m_to_vis = 1'b0;
    m_known = 1'b1;
  endtask

  task automatic model_step(input bit rst_n, input bit en, input bit vld,
                            input logic [3:0] col, input logic [1:0] det);
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!en) return;
    m_add_vis = 1'b0; m_rej_vis = 1'b0; m_to_vis = 1'b0;
    if (m_phase == 0) begin
      if (vld) begin
        m_col = int'(col);
        m_phase = 1;
      end else if (m_timer == TO - 1) begin
        m_to_vis = 1'b1;
        m_turn = !m_turn;
        m_timer = 0;
      end else begin
        m_timer++;
      end
    end else if (m_phase == 1) begin
      if (m_col >= NC || h[m_col] >= NR) begin
        m_rej_vis = 1'b1;
        m_phase = 0;
      end else begin
        m_add_vis = 1'b1;
        m_add_col = m_col;
        m_phase = 2;
      end
    end else if (m_phase >= 2) begin
      if (m_phase == 2) begin
        h[m_col]++;
        if (m_moves < NC * NR) m_moves++;
      end
      if (m_phase == 2 + EW) begin
        if (det == 2'b01 || det == 2'b10) begin
          m_status = int'(det);
          m_phase = -1;
        end else if (m_moves == NC * NR) begin
          m_status = 3;
          m_phase = -1;
        end else begin
          m_turn = !m_turn;
          m_timer = 0;
          m_phase = 0;
        end
      end else begin
        m_phase++;
      end
    end
  endtask

  task automatic cyc(input bit rst_n, input bit en, input bit vld,
                     input logic [3:0] col, input logic [1:0] det);
    logic [NC*CW-1:0] cc;
    @(negedge clk);
    for (int i = 0; i < NC; i++) cc[i*CW +: CW] = CW'(h[i]);
    reset = rst_n; enable = en;
    bus.move_valid = vld; bus.move_col = col; bus.det_status = det; bus.col_counts = cc;
    #1;
    if (m_known) begin
      chk("ready",   32'(bus.move_ready), 32'(en && m_phase == 0));
      chk("add",     32'(bus.add),        32'(en && m_add_vis));
      if (en && m_add_vis) chk("add_col", 32'(bus.add_col), 32'(m_add_col));
      chk("reject",  32'(reject),         32'(en && m_rej_vis));
      chk("timeout", 32'(timeout),        32'(en && m_to_vis));
      chk("turn",    32'(player_turn),    32'(m_turn));
      chk("status",  32'(game_status),    32'(m_status));
    end
    if (timeout === 1'b1) n_to_dut++;
    @(posedge clk);
    model_step(rst_n, en, vld, col, det);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 4'd0, 2'b00);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 2'b00);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0;
    bus.move_valid = 1'b0; bus.move_col = '0; bus.det_status = '0; bus.col_counts = '0;
    do_reset();
    do_reset();

    // Legal move from reset: add two cycles after handshake, turn passes after evaluation.
    cyc(1'b1, 1'b1, 1'b1, 4'd2, 2'b00);
    idle(6);
    chk("t1_turn", 32'(player_turn), 32'd1);
    chk("t1_status", 32'(game_status), 32'd0);

    // Out-of-range column and a full column are both rejected.
    cyc(1'b1, 1'b1, 1'b1, 4'd5, 2'b00);
    idle(3);
    h[1] = NR;
    cyc(1'b1, 1'b1, 1'b1, 4'd1, 2'b00);
    idle(3);
    chk("t2_turn", 32'(player_turn), 32'd1);

    // P1 win is sticky; requests are ignored until reset.
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 4'd0, 2'b01);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 4'd0, 2'b01);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 4'd3, 2'b00);
    chk("t3_status", 32'(game_status), 32'd1);
    chk("t3_ready", 32'(bus.move_ready), 32'd0);
    do_reset();
    idle(1);
    chk("t3_rst_status", 32'(game_status), 32'd0);
    chk("t3_rst_turn", 32'(player_turn), 32'd0);

    // Sixteen legal moves without a winner end in a draw.
    do_reset();
    for (int n = 0; n < 120; n++) begin
      int c = 0;
      for (int i = NC - 1; i >= 0; i--) if (h[i] < NR) c = i;
      cyc(1'b1, 1'b1, 1'b1, 4'(c), 2'b00);
    end
    chk("t4_draw", 32'(game_status), 32'd3);

    // Idle timeouts repeat; a handshake on the expiry cycle wins.
    do_reset();
    n_to_dut = 0;
    idle(20);
    chk("t5_timeouts", 32'(n_to_dut), 32'd2);
    for (int i = 0; i < 2 * TO; i++) if (!(m_phase == 0 && m_timer == TO - 1)) idle(1);
    cyc(1'b1, 1'b1, 1'b1, 4'd0, 2'b00);
    idle(6);

    // Freeze during COMMIT delays the single add; reset mid-EVAL drops the move.
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 4'd3, 2'b00);
    idle(1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 4'd0, 2'b00);
    cyc(1'b1, 1'b1, 1'b0, 4'd0, 2'b00);
    idle(1);
    do_reset();
    idle(3);
    chk("t6_status", 32'(game_status), 32'd0);
    chk("t6_turn", 32'(player_turn), 32'd0);

    // Random play.
    for (int n = 0; n < 3000; n++) begin
      bit rst_n, en, vld;
      logic [3:0] col;
      logic [1:0] det;
      int r;
      rst_n = ($urandom_range(0, 199) != 0);
      if (m_status != 0 && $urandom_range(0, 19) == 0) rst_n = 1'b0;
      en  = ($urandom_range(0, 9) < 9);
      vld = ($urandom_range(0, 9) < 5);
      col = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, NC - 1)) : 4'($urandom_range(NC, 15));
      r = int'($urandom_range(0, 99));
      det = (r < 70) ? 2'b00 : (r < 85) ? 2'b11 : (r < 92) ? 2'b01 : 2'b10;
      cyc(rst_n, en, vld, col, det);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
